aes_arb: RTL and testbench
==========================

AES_ARB -- requirements
Module: aes_arb

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing one AES core (range 2..8).
REQ-002 Parameter TIMEOUT_CYC, default 64, SHALL set the WAIT-state watchdog limit in cycles; it is used only when AES_ARB_TIMEOUT_EN is defined.
REQ-003 clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 req_i  in  N_REQ  SHALL be the per-requester level request, held until that requester's done_o or err_o.
REQ-006 opcode_i  in  N_REQ x aes_pkg::opcode  SHALL be the per-requester opcode, valid while its req_i is high.
REQ-007 gnt_o  out  N_REQ  SHALL be a one-hot grant, with at most one bit set.
REQ-008 gnt_idx_o  out  $clog2(N_REQ)  SHALL be the binary index of the granted requester, for the data mux select.
REQ-009 done_o  out  N_REQ  SHALL be a one-cycle completion pulse to the granted requester.
REQ-010 err_o  out  N_REQ  SHALL be a one-cycle timeout pulse to the granted requester.
REQ-011 start_o  out  1  SHALL drive the core start_i.
REQ-012 opcode_o  out  aes_pkg::opcode  SHALL drive the core opcode_i.
REQ-013 cipher_ready_i, key_ready_i  in  1 each  SHALL be the core completion pulses.
REQ-014 busy_o  out  1  SHALL be high in every state except IDLE.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT and DONE.
REQ-016 In IDLE with any req_i high: select a winner round-robin, searching upward from pointer ptr with wrap at N_REQ; latch the winner index and its opcode; go to ISSUE.
REQ-017 In ISSUE: start_o=1 and opcode_o=latched opcode for exactly one cycle; next state WAIT; for a NOOP opcode, start_o=0 and next state DONE.
REQ-018 gnt_o and gnt_idx_o SHALL be valid from ISSUE through DONE inclusive; gnt_o=0 in IDLE.
REQ-019 opcode_o SHALL be NOOP in every cycle other than ISSUE.
REQ-020 In WAIT, the expected pulse SHALL be key_ready_i for AESKEYGENASSIST and cipher_ready_i for all other opcodes; on the expected pulse, go to DONE.
REQ-021 A ready pulse that is not expected, or that arrives outside WAIT, SHALL be ignored.
REQ-022 In DONE: done_o[winner]=1 for one cycle; ptr=(winner+1) mod N_REQ; next state IDLE.
REQ-023 Latency: req_i seen in IDLE at cycle T gives gnt_o and start_o at T+1; ready at cycle R gives done_o at R+1 and IDLE at R+2.
REQ-024 Back-to-back requests SHALL have a minimum of one IDLE cycle between a DONE and the next ISSUE.
REQ-025 Deassertion of req_i or a change of opcode_i after the grant SHALL be ignored; the latched operation runs to completion and done_o still pulses.
REQ-026 New requests arriving while busy_o=1 SHALL wait and SHALL NOT affect the current grant.
REQ-027 When all N_REQ requesters hold req_i continuously, each SHALL be served once per N_REQ grants.

Reset
REQ-028 With rst high at a clock edge, the FSM SHALL go to IDLE and ptr, gnt_o, gnt_idx_o, done_o, err_o, start_o and busy_o SHALL all be 0, with opcode_o=NOOP.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no done_o and no err_o; the requester must re-request.

Configuration
REQ-030 With AES_ARB_TIMEOUT_EN defined: a WAIT cycle counter SHALL start at 0 on WAIT entry.
REQ-031 With AES_ARB_TIMEOUT_EN defined: reaching TIMEOUT_CYC cycles with no expected pulse SHALL go to DONE, pulsing err_o[winner] instead of done_o and advancing ptr normally.
REQ-032 With AES_ARB_TIMEOUT_EN undefined: no counter SHALL exist, err_o SHALL be tied 0, and WAIT SHALL be left only on the expected pulse.

Verification
REQ-033 Single requester: N_REQ=4, req_i=0001 with AESENC, cipher_ready_i 5 cycles after start_o -> gnt_o=0001 and start_o at T+1, opcode_o=AESENC, done_o=0001 one cycle after ready, then IDLE.
REQ-034 Fairness: req_i=1111 held, each ready after 3 cycles -> grant order 0,1,2,3,0, with a one-cycle IDLE gap between grants.
REQ-035 Wrong ready: AESKEYGENASSIST granted, cipher_ready_i pulsed -> remains in WAIT; key_ready_i pulsed -> done_o.
REQ-036 NOOP request: req_i=0100 with NOOP -> start_o never asserted; done_o=0100 at T+2.
REQ-037 Timeout: macro defined, TIMEOUT_CYC=8, no ready -> err_o pulses 8 cycles after WAIT entry, done_o=0, ptr advanced; macro undefined -> remains in WAIT indefinitely.
REQ-038 Reset mid-WAIT: rst for one cycle -> next cycle all outputs 0, ptr=0, no done_o or err_o.

Source files
------------

// File: rtl/aes_arb.sv
// Round-robin arbiter sharing one AES core among N_REQ requesters.
// Optional WAIT watchdog enabled by defining AES_ARB_TIMEOUT_EN.
// Opcodes are 3 bits: NOOP=0, AESENC=1, AESENCLAST=2, AESDEC=3, AESDECLAST=4,
// AESKEYGENASSIST=5, AESIMC=6.
module aes_arb #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = 64,
    localparam int unsigned IDX_W      = $clog2(N_REQ),
    localparam int unsigned OP_W       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [N_REQ*OP_W-1:0] opcode_i,
    output logic [N_REQ-1:0]      gnt_o,
    output logic [IDX_W-1:0]      gnt_idx_o,
    output logic [N_REQ-1:0]      done_o,
    output logic [N_REQ-1:0]      err_o,
    output logic                  start_o,
    output logic [OP_W-1:0]       opcode_o,
    input  logic                  cipher_ready_i,
    input  logic                  key_ready_i,
    output logic                  busy_o
);

    localparam logic [OP_W-1:0] OP_NOOP   = 3'd0;
    localparam logic [OP_W-1:0] OP_KEYGEN = 3'd5;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] winner_q, winner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             err_q, err_d;
    logic             found;
    logic [IDX_W-1:0] pick;
    logic [OP_W-1:0]  pick_op;
    logic             expected;
    logic             timeout;

    // First requester at or above ptr, wrapping at N_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req_i[IDX_W'((32'(ptr_q) + i) % N_REQ)]) begin
                found = 1'b1;
                pick  = IDX_W'((32'(ptr_q) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        pick_op = OP_NOOP;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == pick) pick_op = opcode_i[i*OP_W +: OP_W];
        end
    end

    assign expected = (op_q == OP_KEYGEN) ? key_ready_i : cipher_ready_i;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;

    // Zero on every WAIT entry because it is cleared in all other states.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == StWait) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout = (state_q == StWait) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            winner_q <= '0;
            ptr_q    <= '0;
            op_q     <= OP_NOOP;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            ptr_q    <= ptr_d;
            op_q     <= op_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        ptr_d     = ptr_q;
        op_d      = op_q;
        err_d     = err_q;
        gnt_o     = '0;
        gnt_idx_o = '0;
        done_o    = '0;
        err_o     = '0;
        start_o   = 1'b0;
        opcode_o  = OP_NOOP;
        busy_o    = (state_q != StIdle);
        if (state_q != StIdle) begin
            gnt_o[winner_q] = 1'b1;
            gnt_idx_o       = winner_q;
        end
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    winner_d = pick;
                    op_d     = pick_op;
                    err_d    = 1'b0;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (op_q == OP_NOOP) begin
                    state_d = StDone;
                end else begin
                    start_o  = 1'b1;
                    opcode_o = op_q;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (expected) begin
                    state_d = StDone;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (err_q) err_o[winner_q] = 1'b1;
                else       done_o[winner_q] = 1'b1;
                ptr_d   = (winner_q == IDX_W'(N_REQ - 1)) ? '0 : winner_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_aes_arb.sv
// Randomized self-checking bench for aes_arb against a transaction-level model.
// Honours AES_ARB_TIMEOUT_EN the same way as the design.
module tb_aes_arb;

    localparam int N = 4;
    localparam logic [2:0] NOOP = 3'd0, AESENC = 3'd1, KEYGEN = 3'd5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_i;
    logic [N*3-1:0] opcode_i;
    logic [N-1:0]   gnt_o, done_o, err_o;
    logic [1:0]     gnt_idx_o;
    logic           start_o, busy_o, cipher_ready_i, key_ready_i;
    logic [2:0]     opcode_o;

    aes_arb #(.N_REQ(N), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .opcode_i(opcode_i), .gnt_o(gnt_o),
        .gnt_idx_o(gnt_idx_o), .done_o(done_o), .err_o(err_o), .start_o(start_o),
        .opcode_o(opcode_o), .cipher_ready_i(cipher_ready_i), .key_ready_i(key_ready_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Model: pending requesters, their opcodes, and the round-robin pointer.
    bit       pend[N];
    logic [2:0] pop[N];
    int       ptr_m;
    int       checks = 0;
    int       errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input bit busy, input bit start, input logic [3:0] gnt,
                                         input logic [1:0] idx, input logic [3:0] done,
                                         input logic [3:0] err, input logic [2:0] op);
        return {13'b0, busy, start, gnt, idx, done, err, op};
    endfunction

    function automatic logic [31:0] outs();
        return pack(busy_o, start_o, gnt_o, gnt_idx_o, done_o, err_o, opcode_o);
    endfunction

    function automatic int rr_pick();
        for (int k = 0; k < N; k++) if (pend[(ptr_m + k) % N]) return (ptr_m + k) % N;
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int k = 0; k < N; k++) if (pend[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < N; k++) begin
            req_i[k]          = pend[k];
            opcode_i[k*3 +: 3] = pop[k];
        end
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic run_txn(input int wait_cyc, input bit noise, input bit hold,
                           output int got_idx);
        int         w;
        logic [2:0] op;
        logic [3:0] oh;
        drive_reqs();
        w  = rr_pick();
        op = pop[w];
        oh = 4'(1 << w);
        tick();
        got_idx = int'(gnt_idx_o);
        check_eq("issue", outs(), pack(1, op != NOOP, oh, 2'(w), 0, 0, op));
        if (noise) begin
            for (int k = 0; k < N; k++) begin
                if (k != w && !pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k] = 1'b1;
                    pop[k]  = 3'($urandom_range(0, 6));
                end
            end
            drive_reqs();
            opcode_i[w*3 +: 3] = 3'($urandom);
            req_i[w]           = 1'($urandom);
            cipher_ready_i     = 1'($urandom);
            key_ready_i        = 1'($urandom);
        end
        if (op != NOOP) begin
            tick();
            cipher_ready_i = 1'b0;
            key_ready_i    = 1'b0;
            check_eq("wait", outs(), pack(1, 0, oh, 2'(w), 0, 0, NOOP));
            for (int c = 0; c < wait_cyc; c++) begin
                if (noise) begin
                    if (op == KEYGEN) cipher_ready_i = 1'b1;
                    else              key_ready_i    = 1'b1;
                end
                tick();
                cipher_ready_i = 1'b0;
                key_ready_i    = 1'b0;
                check_eq("wait_hold", outs(), pack(1, 0, oh, 2'(w), 0, 0, NOOP));
            end
            if (op == KEYGEN) key_ready_i    = 1'b1;
            else              cipher_ready_i = 1'b1;
        end
        tick();
        cipher_ready_i = 1'b0;
        key_ready_i    = 1'b0;
        check_eq("done", outs(), pack(1, 0, oh, 2'(w), oh, 0, NOOP));
        if (!hold) pend[w] = 1'b0;
        ptr_m = (w + 1) % N;
        drive_reqs();
        if (noise) begin
            cipher_ready_i = 1'($urandom);
            key_ready_i    = 1'($urandom);
        end
        tick();
        cipher_ready_i = 1'b0;
        key_ready_i    = 1'b0;
        check_eq("idle_gap", outs(), pack(0, 0, 0, 0, 0, 0, NOOP));
    endtask

    task automatic drain();
        int g;
        for (int i = 0; i < 16 && any_pend(); i++) run_txn(1, 0, 0, g);
    endtask

    initial begin
        int         g;
        int         start;
        int         w;
        logic [3:0] oh;
        rst            = 1'b1;
        req_i          = '0;
        opcode_i       = '0;
        cipher_ready_i = 1'b0;
        key_ready_i    = 1'b0;
        ptr_m          = 0;
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0;
            pop[k]  = NOOP;
        end
        tick();
        tick();
        check_eq("reset", outs(), pack(0, 0, 0, 0, 0, 0, NOOP));
        req_i = '1;
        tick();
        check_eq("reset_hold", outs(), pack(0, 0, 0, 0, 0, 0, NOOP));
        rst   = 1'b0;
        req_i = '0;
        tick();
        check_eq("idle", outs(), pack(0, 0, 0, 0, 0, 0, NOOP));

        // Single AESENC requester, ready well after start.
        pend[0] = 1'b1;
        pop[0]  = AESENC;
        run_txn(4, 0, 0, g);
        check_eq("single_idx", 32'(g), 0);

        // NOOP skips the core entirely.
        pend[2] = 1'b1;
        pop[2]  = NOOP;
        run_txn(0, 0, 0, g);

        // Keygen ignores cipher_ready while waiting.
        pend[1] = 1'b1;
        pop[1]  = KEYGEN;
        run_txn(3, 1, 0, g);
        drain();

        // All requesters held: strict rotation.
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b1;
            pop[k]  = 3'($urandom_range(0, 6));
        end
        start = ptr_m;
        for (int k = 0; k < 5; k++) begin
            run_txn(3, 0, 1, g);
            check_eq("fair_order", 32'(g), 32'((start + k) % N));
        end
        for (int k = 0; k < N; k++) pend[k] = 1'b0;

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            if (!any_pend()) begin
                w       = $urandom_range(0, N - 1);
                pend[w] = 1'b1;
                pop[w]  = 3'($urandom_range(0, 6));
            end
            run_txn($urandom_range(0, 5), 1'($urandom), 0, g);
        end
        drain();

        // Watchdog behaviour.
        pend[1] = 1'b1;
        pop[1]  = AESENC;
        drive_reqs();
        w  = rr_pick();
        oh = 4'(1 << w);
        tick();
        check_eq("to_issue", outs(), pack(1, 1, oh, 2'(w), 0, 0, AESENC));
        tick();
        check_eq("to_wait", outs(), pack(1, 0, oh, 2'(w), 0, 0, NOOP));
`ifdef AES_ARB_TIMEOUT_EN
        for (int c = 1; c < 8; c++) begin
            tick();
            check_eq("to_count", outs(), pack(1, 0, oh, 2'(w), 0, 0, NOOP));
        end
        tick();
        check_eq("to_err", outs(), pack(1, 0, oh, 2'(w), 0, oh, NOOP));
`else
        for (int c = 0; c < 20; c++) begin
            tick();
            check_eq("no_to", outs(), pack(1, 0, oh, 2'(w), 0, 0, NOOP));
        end
        cipher_ready_i = 1'b1;
        tick();
        cipher_ready_i = 1'b0;
        check_eq("no_to_done", outs(), pack(1, 0, oh, 2'(w), oh, 0, NOOP));
`endif
        pend[w] = 1'b0;
        ptr_m   = (w + 1) % N;
        drive_reqs();
        tick();
        check_eq("to_idle", outs(), pack(0, 0, 0, 0, 0, 0, NOOP));
        pend[0] = 1'b1;
        pop[0]  = AESENC;
        pend[2] = 1'b1;
        pop[2]  = NOOP;
        run_txn(1, 0, 0, g);
        check_eq("to_ptr", 32'(g), 2);
        drain();

        // Reset in the middle of WAIT aborts silently and clears ptr.
        pend[2] = 1'b1;
        pop[2]  = AESENC;
        drive_reqs();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("rst_wait", outs(), pack(0, 0, 0, 0, 0, 0, NOOP));
        rst   = 1'b0;
        req_i = '0;
        tick();
        check_eq("post_rst", outs(), pack(0, 0, 0, 0, 0, 0, NOOP));
        ptr_m = 0;
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b1;
            pop[k]  = AESENC;
        end
        run_txn(2, 0, 0, g);
        check_eq("rst_ptr", 32'(g), 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
